// File: rtl/fios_mem_pkg.sv
// Shared types and helpers for the FIOS memory sequencer: FSM states,
// operand select encoding, read-tag layout and BRAM region addressing.
package fios_mem_pkg;

  localparam int IDX_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_ISSUE,
    ST_LOAD_DRAIN,
    ST_STORE,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_N = 2'd2
  } op_sel_t;

  typedef struct packed {
    logic             vld;
    op_sel_t          sel;
    logic [IDX_W-1:0] idx;
  } rd_tag_t;

  // BRAM layout: region 0 = A, 1 = B, 2 = N, 3 = result, each num_words long.
  function automatic int base(input logic [1:0] region, input int num_words);
    return int'(region) * num_words;
  endfunction

endpackage

// File: rtl/fios_rd_tag_pipe.sv
// Delay line that carries each BRAM read's operand tag alongside the read
// latency, so the tag emerges in the same cycle as the read data.
module fios_rd_tag_pipe
  import fios_mem_pkg::*;
#(
  parameter int BRAM_LAT = 2
) (
  input  logic    clock_i,
  input  logic    reset_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o,
  output logic    inflight_o
);

  rd_tag_t tag_q [BRAM_LAT];
  rd_tag_t tag_d [BRAM_LAT];

  // inflight_o ignores the output stage: it is true while reads remain beyond this cycle.
  always_comb begin
    tag_d[0] = tag_i;
    for (int i = 1; i < BRAM_LAT; i++) tag_d[i] = tag_q[i-1];
    inflight_o = 1'b0;
    for (int i = 0; i < BRAM_LAT - 1; i++) inflight_o = inflight_o | tag_q[i].vld;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < BRAM_LAT; i++) tag_q[i] <= '0;
    end else begin
      for (int i = 0; i < BRAM_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign tag_o = tag_q[BRAM_LAT-1];

endmodule

// File: rtl/fios_mem_ctrl.sv
// Sequencer between operand/result BRAM and the FIOS datapath: loads A, B, N
// into the operand registers or stores result words back, one word per cycle.
module fios_mem_ctrl
  import fios_mem_pkg::*;
#(
  parameter int WORD_W    = 64,
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 8,
  parameter int BRAM_LAT  = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              mem_start_i,
  input  logic              load_store_i,
  output logic              load_done_o,
  output logic              store_done_o,
  output logic              busy_o,
  output logic              bram_en_o,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [WORD_W-1:0] bram_wdata_o,
  input  logic [WORD_W-1:0] bram_rdata_i,
  output logic              op_we_o,
  output logic [1:0]        op_sel_o,
  output logic [IDX_W-1:0]  op_idx_o,
  output logic [WORD_W-1:0] op_data_o,
  output logic              res_rd_o,
  output logic [IDX_W-1:0]  res_idx_o,
  input  logic [WORD_W-1:0] res_data_i
);

  if ((1 << ADDR_W) < 4 * NUM_WORDS) begin : g_addr_chk
    $error("fios_mem_ctrl: ADDR_W cannot address 4*NUM_WORDS words");
  end
  if (NUM_WORDS < 1 || NUM_WORDS > 64) begin : g_words_chk
    $error("fios_mem_ctrl: NUM_WORDS must be 1..64");
  end
  if (BRAM_LAT < 1 || BRAM_LAT > 4) begin : g_lat_chk
    $error("fios_mem_ctrl: BRAM_LAT must be 1..4");
  end

  localparam logic [ADDR_W-1:0] LD_LAST  = ADDR_W'(base(2'd3, NUM_WORDS) - 1);
  localparam logic [ADDR_W-1:0] ST_BASE  = ADDR_W'(base(2'd3, NUM_WORDS));
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_WORDS - 1);

  state_t              state_q, state_d;
  logic                en_q, en_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  op_sel_t             sel_q, sel_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                rd_q, rd_d;
  logic [IDX_W-1:0]    ridx_q, ridx_d;
  logic                ld_done_q, ld_done_d;
  logic                st_done_q, st_done_d;
  logic                busy_q, busy_d;

  rd_tag_t             tag_in, tag_out;
  logic                inflight;

  always_comb begin
    tag_in.vld = en_q;
    tag_in.sel = en_q ? sel_q : SEL_A;
    tag_in.idx = en_q ? idx_q : '0;
  end

  fios_rd_tag_pipe #(
    .BRAM_LAT (BRAM_LAT)
  ) u_tag_pipe (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .tag_i      (tag_in),
    .tag_o      (tag_out),
    .inflight_o (inflight)
  );

  always_comb begin
    state_d   = state_q;
    en_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = '0;
    sel_d     = sel_q;
    idx_d     = idx_q;
    rd_d      = 1'b0;
    ridx_d    = ridx_q;
    ld_done_d = 1'b0;
    st_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_start_i) begin
          sel_d  = SEL_A;
          idx_d  = '0;
          ridx_d = '0;
          if (load_store_i) begin
            state_d = ST_STORE;
            rd_d    = 1'b1;
          end else begin
            state_d = ST_LOAD_ISSUE;
            en_d    = 1'b1;
          end
        end
      end

      // The registered read (en_q/addr_q/sel_q/idx_q) is the one issued this cycle.
      ST_LOAD_ISSUE: begin
        if (addr_q == LD_LAST) begin
          state_d = ST_LOAD_DRAIN;
        end else begin
          en_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            sel_d = (sel_q == SEL_A) ? SEL_B : SEL_N;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_LOAD_DRAIN: begin
        if (ld_done_q) begin
          state_d = mem_start_i ? ST_RELEASE : ST_IDLE;
        end else if (!inflight) begin
          ld_done_d = 1'b1;
        end
      end

      // Result data arrives one cycle after res_rd, so the write trails the read.
      ST_STORE: begin
        if (rd_q) begin
          we_d   = 1'b1;
          addr_d = ST_BASE + ADDR_W'(ridx_q);
          if (ridx_q != IDX_LAST) begin
            rd_d   = 1'b1;
            ridx_d = ridx_q + IDX_W'(1);
          end
        end
        if (st_done_q) begin
          state_d = mem_start_i ? ST_RELEASE : ST_IDLE;
        end else if (we_q && !rd_q) begin
          st_done_d = 1'b1;
        end
      end

      ST_RELEASE: begin
        if (!mem_start_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_LOAD_ISSUE) || (state_d == ST_LOAD_DRAIN) ||
             (state_d == ST_STORE);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      sel_q     <= SEL_A;
      idx_q     <= '0;
      rd_q      <= 1'b0;
      ridx_q    <= '0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      rd_q      <= rd_d;
      ridx_q    <= ridx_d;
      ld_done_q <= ld_done_d;
      st_done_q <= st_done_d;
      busy_q    <= busy_d;
    end
  end

  assign load_done_o  = ld_done_q;
  assign store_done_o = st_done_q;
  assign busy_o       = busy_q;
  assign bram_en_o    = en_q;
  assign bram_we_o    = we_q;
  assign bram_addr_o  = addr_q;
  assign bram_wdata_o = we_q ? res_data_i : '0;
  assign op_we_o      = tag_out.vld;
  assign op_sel_o     = tag_out.sel;
  assign op_idx_o     = tag_out.idx;
  assign op_data_o    = bram_rdata_i;
  assign res_rd_o     = rd_q;
  assign res_idx_o    = ridx_q;

endmodule

// File: tb/tb_fios_mem_ctrl.sv
// Directed bench for fios_mem_ctrl (N=4, BRAM_LAT=2) with event scoreboards
// for BRAM reads, operand writes, result reads and BRAM writes.
module tb_fios_mem_ctrl;

  localparam int WORD_W    = 64;
  localparam int NUM_WORDS = 4;
  localparam int ADDR_W    = 8;
  localparam int BRAM_LAT  = 2;

  logic              clock_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              mem_start_i = 1'b0;
  logic              load_store_i = 1'b0;
  logic              load_done_o, store_done_o, busy_o;
  logic              bram_en_o, bram_we_o;
  logic [ADDR_W-1:0] bram_addr_o;
  logic [WORD_W-1:0] bram_wdata_o;
  logic [WORD_W-1:0] bram_rdata_i = '0;
  logic              op_we_o;
  logic [1:0]        op_sel_o;
  logic [5:0]        op_idx_o;
  logic [WORD_W-1:0] op_data_o;
  logic              res_rd_o;
  logic [5:0]        res_idx_o;
  logic [WORD_W-1:0] res_data_i = '0;

  fios_mem_ctrl #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W),
    .BRAM_LAT  (BRAM_LAT)
  ) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .mem_start_i  (mem_start_i),
    .load_store_i (load_store_i),
    .load_done_o  (load_done_o),
    .store_done_o (store_done_o),
    .busy_o       (busy_o),
    .bram_en_o    (bram_en_o),
    .bram_we_o    (bram_we_o),
    .bram_addr_o  (bram_addr_o),
    .bram_wdata_o (bram_wdata_o),
    .bram_rdata_i (bram_rdata_i),
    .op_we_o      (op_we_o),
    .op_sel_o     (op_sel_o),
    .op_idx_o     (op_idx_o),
    .op_data_o    (op_data_o),
    .res_rd_o     (res_rd_o),
    .res_idx_o    (res_idx_o),
    .res_data_i   (res_data_i)
  );

  always #5 clock_i = ~clock_i;

  // BRAM holds 0x100+addr; two-cycle read latency. Result words are 0xA0+idx.
  logic [WORD_W-1:0] rd_p0 = '0;
  always @(posedge clock_i) begin
    rd_p0        <= bram_en_o ? (64'h100 + 64'(bram_addr_o)) : '0;
    bram_rdata_i <= rd_p0;
    if (res_rd_o) res_data_i <= 64'hA0 + 64'(res_idx_o);
  end

  typedef struct {
    int          cyc;
    logic [63:0] key;
    logic [63:0] data;
  } ev_t;

  ev_t q_rd[$];
  ev_t q_op[$];
  ev_t q_res[$];
  ev_t q_wr[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_ld = -1;
  int exp_st = -1;
  int b_lo = 1;
  int b_hi = 0;
  int s;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_load(input int st);
    logic [7:0] k;
    for (int a = 0; a < 3 * NUM_WORDS; a++) begin
      k = {2'(a / NUM_WORDS), 6'(a % NUM_WORDS)};
      q_rd.push_back('{st + 1 + a, 64'(a), 64'h0});
      q_op.push_back('{st + 1 + BRAM_LAT + a, 64'(k), 64'h100 + 64'(a)});
    end
    exp_ld = st + 3 * NUM_WORDS + BRAM_LAT + 1;
    b_lo   = st + 1;
    b_hi   = exp_ld;
  endtask

  task automatic push_store(input int st);
    for (int i = 0; i < NUM_WORDS; i++) begin
      q_res.push_back('{st + 1 + i, 64'(i), 64'h0});
      q_wr.push_back('{st + 2 + i, 64'(3 * NUM_WORDS + i), 64'hA0 + 64'(i)});
    end
    exp_st = st + NUM_WORDS + 2;
    b_lo   = st + 1;
    b_hi   = exp_st;
  endtask

  // Advance to the next negedge and score everything the DUT shows in that cycle.
  task automatic cycle();
    ev_t e;
    @(negedge clock_i);
    cyc++;
    if (bram_en_o) begin
      if (q_rd.size() == 0) cmp("rd_unexpected", 64'(bram_en_o), 64'h0);
      else begin
        e = q_rd.pop_front();
        cmp("rd_cycle", 64'(cyc), 64'(e.cyc));
        cmp("rd_addr", 64'(bram_addr_o), e.key);
      end
    end
    if (op_we_o) begin
      if (q_op.size() == 0) cmp("op_we_unexpected", 64'(op_we_o), 64'h0);
      else begin
        e = q_op.pop_front();
        cmp("op_cycle", 64'(cyc), 64'(e.cyc));
        cmp("op_sel_idx", 64'({op_sel_o, op_idx_o}), e.key);
        cmp("op_data", op_data_o, e.data);
      end
    end
    if (res_rd_o) begin
      if (q_res.size() == 0) cmp("res_rd_unexpected", 64'(res_rd_o), 64'h0);
      else begin
        e = q_res.pop_front();
        cmp("res_cycle", 64'(cyc), 64'(e.cyc));
        cmp("res_idx", 64'(res_idx_o), e.key);
      end
    end
    if (bram_we_o) begin
      if (q_wr.size() == 0) cmp("wr_unexpected", 64'(bram_we_o), 64'h0);
      else begin
        e = q_wr.pop_front();
        cmp("wr_cycle", 64'(cyc), 64'(e.cyc));
        cmp("wr_addr", 64'(bram_addr_o), e.key);
        cmp("wr_data", bram_wdata_o, e.data);
      end
    end
    cmp("en_we_overlap", 64'(bram_en_o & bram_we_o), 64'h0);
    cmp("load_done", 64'(load_done_o), 64'(cyc == exp_ld));
    cmp("store_done", 64'(store_done_o), 64'(cyc == exp_st));
    cmp("busy", 64'(busy_o), 64'(cyc >= b_lo && cyc <= b_hi));
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_busy"}, 64'(busy_o), 64'h0);
    cmp({tag, "_ld_done"}, 64'(load_done_o), 64'h0);
    cmp({tag, "_st_done"}, 64'(store_done_o), 64'h0);
    cmp({tag, "_en"}, 64'(bram_en_o), 64'h0);
    cmp({tag, "_we"}, 64'(bram_we_o), 64'h0);
    cmp({tag, "_addr"}, 64'(bram_addr_o), 64'h0);
    cmp({tag, "_wdata"}, bram_wdata_o, 64'h0);
    cmp({tag, "_op_we"}, 64'(op_we_o), 64'h0);
    cmp({tag, "_op_sel"}, 64'(op_sel_o), 64'h0);
    cmp({tag, "_op_idx"}, 64'(op_idx_o), 64'h0);
    cmp({tag, "_res_rd"}, 64'(res_rd_o), 64'h0);
    cmp({tag, "_res_idx"}, 64'(res_idx_o), 64'h0);
  endtask

  task automatic drained(input string tag);
    cmp({tag, "_rd_left"}, 64'(q_rd.size()), 64'h0);
    cmp({tag, "_op_left"}, 64'(q_op.size()), 64'h0);
    cmp({tag, "_res_left"}, 64'(q_res.size()), 64'h0);
    cmp({tag, "_wr_left"}, 64'(q_wr.size()), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cycle();
    cycle();
    check_zero("reset");
    reset_i = 1'b0;
    cycle();

    // Plain load, start held until the done pulse.
    s = cyc; mem_start_i = 1'b1; load_store_i = 1'b0; push_load(s);
    while (cyc < s + 15) cycle();
    mem_start_i = 1'b0;
    repeat (3) cycle();
    drained("load");

    // Store of four result words.
    s = cyc; mem_start_i = 1'b1; load_store_i = 1'b1; push_store(s);
    while (cyc < s + 6) cycle();
    mem_start_i = 1'b0; load_store_i = 1'b0;
    repeat (3) cycle();
    drained("store");

    // Start held 20 cycles past done, then dropped and re-raised.
    s = cyc; mem_start_i = 1'b1; push_load(s);
    while (cyc < s + 35) cycle();
    mem_start_i = 1'b0;
    cycle();
    s = cyc; mem_start_i = 1'b1; push_load(s);
    while (cyc < s + 15) cycle();
    mem_start_i = 1'b0;
    repeat (3) cycle();
    drained("hold");

    // Reset in cycle 5 of a load, then a clean reload.
    s = cyc; mem_start_i = 1'b1; push_load(s);
    while (cyc < s + 5) cycle();
    reset_i = 1'b1;
    #1;
    check_zero("rst_mid");
    q_rd.delete(); q_op.delete(); q_res.delete(); q_wr.delete();
    exp_ld = -1; b_lo = 1; b_hi = 0;
    mem_start_i = 1'b0;
    cycle();
    reset_i = 1'b0;
    cycle();
    s = cyc; mem_start_i = 1'b1; push_load(s);
    while (cyc < s + 15) cycle();
    mem_start_i = 1'b0;
    repeat (3) cycle();
    drained("reload");

    // Start dropped in cycle 3; a store launched in cycle 16 proves IDLE there.
    s = cyc; mem_start_i = 1'b1; load_store_i = 1'b0; push_load(s);
    while (cyc < s + 3) cycle();
    mem_start_i = 1'b0;
    while (cyc < s + 16) cycle();
    s = cyc; mem_start_i = 1'b1; load_store_i = 1'b1; push_store(s);
    while (cyc < s + 6) cycle();
    mem_start_i = 1'b0; load_store_i = 1'b0;
    repeat (3) cycle();
    drained("early");

    // Load, then store two cycles after start goes low.
    s = cyc; mem_start_i = 1'b1; push_load(s);
    while (cyc < s + 15) cycle();
    mem_start_i = 1'b0;
    cycle();
    cycle();
    s = cyc; mem_start_i = 1'b1; load_store_i = 1'b1; push_store(s);
    while (cyc < s + 6) cycle();
    mem_start_i = 1'b0; load_store_i = 1'b0;
    repeat (3) cycle();
    drained("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
